// File: rtl/bd_bus_pkg.sv
// bd_bus_pkg -- shared definitions for the buffered-bus scheduler.
// Holds the scheduler state encoding, the device-select constants and the
// fixed SETUP/HOLD phase lengths, plus a helper that picks the strobe width
// for the addressed device.
// Optional feature macro: BD_TURNAROUND_EN adds the TURN state.
package bd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
`ifdef BD_TURNAROUND_EN
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
`else
        ST_HOLD   = 3'd3
`endif
    } state_t;

    localparam logic DEV_W5300 = 1'b0;
    localparam logic DEV_SL811 = 1'b1;

    // SETUP and HOLD each occupy exactly one clock.
    localparam int SETUP_LEN = 1;
    localparam int HOLD_LEN  = 1;

    // Strobe width (in clocks) for the addressed device.
    function automatic logic [3:0] strobe_len(input logic dev,
                                              input logic [3:0] w_len,
                                              input logic [3:0] s_len);
        logic [3:0] len;
        if (dev == DEV_W5300) begin
            len = w_len;
        end else begin
            len = s_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/bd_bus_sched_if.sv
// bd_bus_sched_if -- requester handshake and buffered-bus signal bundle.
// slave modport: the scheduler (takes requests and bd_in, drives acks,
//   read data and the buffered bus).
// master modport: the environment (requesters plus the bus devices).
interface bd_bus_sched_if;
    logic       r0_req;
    logic       r0_rnw;
    logic       r0_dev;
    logic [9:0] r0_addr;
    logic [7:0] r0_wdata;
    logic       r0_ack;
    logic       r1_req;
    logic       r1_rnw;
    logic       r1_dev;
    logic [9:0] r1_addr;
    logic [7:0] r1_wdata;
    logic       r1_ack;
    logic [7:0] rdata;
    logic [7:0] bd_out;
    logic       bd_oe;
    logic [7:0] bd_in;
    logic       brd_n;
    logic       bwr_n;
    logic       w5300_cs_n;
    logic [9:0] w5300_addr;
    logic       sl811_cs_n;
    logic       sl811_a0;

    modport slave (
        input  r0_req, r0_rnw, r0_dev, r0_addr, r0_wdata,
        input  r1_req, r1_rnw, r1_dev, r1_addr, r1_wdata,
        input  bd_in,
        output r0_ack, r1_ack, rdata, bd_out, bd_oe, brd_n, bwr_n,
        output w5300_cs_n, w5300_addr, sl811_cs_n, sl811_a0
    );

    modport master (
        output r0_req, r0_rnw, r0_dev, r0_addr, r0_wdata,
        output r1_req, r1_rnw, r1_dev, r1_addr, r1_wdata,
        output bd_in,
        input  r0_ack, r1_ack, rdata, bd_out, bd_oe, brd_n, bwr_n,
        input  w5300_cs_n, w5300_addr, sl811_cs_n, sl811_a0
    );
endinterface

// File: rtl/bd_bus_arb.sv
// bd_bus_arb -- two-port arbiter with port-1 starvation guard.
// Port 0 has fixed priority; each port-0 grant made while port 1 is waiting
// bumps a starve counter, and once it reaches STARVE_MAX port 1 takes the
// next grant. Any port-1 grant, or a port-0 grant with port 1 idle, clears it.
// Ports: clk, rst_n (async active-low), r0_req, r1_req, grant_en (a grant is
//   being taken this cycle), gnt1 (1 = port 1 selected, combinational).
module bd_bus_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic r0_req,
    input  logic r1_req,
    input  logic grant_en,
    output logic gnt1
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_r;
    logic          starved_s;

    // Grant selection: port 1 wins when alone or when port 0 has starved it.
    always_comb begin
        starved_s = (starve_r >= CW'(STARVE_MAX));
        if (r1_req && (!r0_req || starved_s)) begin
            gnt1 = 1'b1;
        end else begin
            gnt1 = 1'b0;
        end
    end

    // Starve counter, updated only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= '0;
        end else if (grant_en) begin
            if (gnt1) begin
                starve_r <= '0;
            end else if (r1_req) begin
                starve_r <= starve_r + CW'(1);
            end else begin
                starve_r <= '0;
            end
        end else begin
            starve_r <= starve_r;
        end
    end
endmodule

// File: rtl/bd_bus_sched_chk.sv
// bd_bus_sched_chk -- protocol checker for the buffered-bus scheduler.
// Flags two chip selects low together, both strobes low together, or both
// requester acks in the same cycle.
// Ports: clk, rst_n and the observed bus/ack outputs (all inputs).
module bd_bus_sched_chk (
    input logic clk,
    input logic rst_n,
    input logic w5300_cs_n,
    input logic sl811_cs_n,
    input logic brd_n,
    input logic bwr_n,
    input logic r0_ack,
    input logic r1_ack
);
    a_one_cs: assert property (@(posedge clk) disable iff (!rst_n)
        (w5300_cs_n || sl811_cs_n));

    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        (brd_n || bwr_n));

    a_one_ack: assert property (@(posedge clk) disable iff (!rst_n)
        !(r0_ack && r1_ack));
endmodule

// File: rtl/bd_bus_sched.sv
// bd_bus_sched -- schedules two requesters onto the shared buffered bus
// serving a W5300 and an SL811.
// Each cycle runs IDLE -> SETUP (1 clk) -> STROBE (W_STB or S_STB clks)
// -> HOLD (1 clk, ack) -> IDLE. All bus outputs are registered.
// Ports: clk, rst_n (async active-low), bus (bd_bus_sched_if.slave: request
//   handshakes for ports 0/1, read data, buffered-bus data/strobes/selects).
// Optional macro BD_TURNAROUND_EN: a write granted straight after a read
//   passes through one idle TURN cycle before SETUP.
module bd_bus_sched
    import bd_bus_pkg::*;
#(
    parameter int W_STB      = 3,
    parameter int S_STB      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bd_bus_sched_if.slave   bus
);
    state_t     state_r;
    logic       gnt1_r, rnw_r, dev_r;
    logic [9:0] addr_r;
    logic [7:0] wdata_r;
    logic [3:0] stb_cnt_r;
    logic       r0_ack_r, r1_ack_r, bd_oe_r, brd_n_r, bwr_n_r;
    logic       w5300_cs_n_r, sl811_cs_n_r, sl811_a0_r;
    logic [7:0] rdata_r, bd_out_r;
    logic [9:0] w5300_addr_r;

    logic       any_req_s, grant_en_s, gnt1_s, enter_setup_s;
    logic       sel_rnw_s, sel_dev_s, set_rnw_s, set_dev_s;
    logic [9:0] sel_addr_s, set_addr_s;
    logic [7:0] sel_wdata_s, set_wdata_s;

    assign any_req_s  = bus.r0_req | bus.r1_req;
    assign grant_en_s = (state_r == ST_IDLE) && any_req_s;

    bd_bus_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0_req   (bus.r0_req),
        .r1_req   (bus.r1_req),
        .grant_en (grant_en_s),
        .gnt1     (gnt1_s)
    );

    // Request fields of the port the arbiter picked.
    always_comb begin
        sel_rnw_s   = bus.r0_rnw;
        sel_dev_s   = bus.r0_dev;
        sel_addr_s  = bus.r0_addr;
        sel_wdata_s = bus.r0_wdata;
        if (gnt1_s) begin
            sel_rnw_s   = bus.r1_rnw;
            sel_dev_s   = bus.r1_dev;
            sel_addr_s  = bus.r1_addr;
            sel_wdata_s = bus.r1_wdata;
        end else begin
            sel_rnw_s   = bus.r0_rnw;
            sel_dev_s   = bus.r0_dev;
            sel_addr_s  = bus.r0_addr;
            sel_wdata_s = bus.r0_wdata;
        end
    end

`ifdef BD_TURNAROUND_EN
    logic last_rd_r;
    logic need_turn_s;

    // A write granted immediately after a completed read needs a turn cycle.
    assign need_turn_s   = last_rd_r && !sel_rnw_s;
    assign enter_setup_s = (grant_en_s && !need_turn_s) || (state_r == ST_TURN);

    // SETUP is loaded from the live request out of IDLE, or from the
    // already-latched request when leaving TURN.
    always_comb begin
        set_rnw_s   = sel_rnw_s;
        set_dev_s   = sel_dev_s;
        set_addr_s  = sel_addr_s;
        set_wdata_s = sel_wdata_s;
        if (state_r == ST_TURN) begin
            set_rnw_s   = rnw_r;
            set_dev_s   = dev_r;
            set_addr_s  = addr_r;
            set_wdata_s = wdata_r;
        end else begin
            set_rnw_s   = sel_rnw_s;
            set_dev_s   = sel_dev_s;
            set_addr_s  = sel_addr_s;
            set_wdata_s = sel_wdata_s;
        end
    end
`else
    assign enter_setup_s = grant_en_s;

    // SETUP is always loaded from the live request out of IDLE.
    always_comb begin
        set_rnw_s   = sel_rnw_s;
        set_dev_s   = sel_dev_s;
        set_addr_s  = sel_addr_s;
        set_wdata_s = sel_wdata_s;
    end
`endif

    // Bus-cycle FSM with registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gnt1_r       <= 1'b0;
            rnw_r        <= 1'b0;
            dev_r        <= 1'b0;
            addr_r       <= 10'd0;
            wdata_r      <= 8'd0;
            stb_cnt_r    <= 4'd0;
            r0_ack_r     <= 1'b0;
            r1_ack_r     <= 1'b0;
            bd_oe_r      <= 1'b0;
            brd_n_r      <= 1'b1;
            bwr_n_r      <= 1'b1;
            w5300_cs_n_r <= 1'b1;
            sl811_cs_n_r <= 1'b1;
            sl811_a0_r   <= 1'b0;
            rdata_r      <= 8'd0;
            bd_out_r     <= 8'd0;
            w5300_addr_r <= 10'd0;
`ifdef BD_TURNAROUND_EN
            last_rd_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt1_r  <= gnt1_s;
                        rnw_r   <= sel_rnw_s;
                        dev_r   <= sel_dev_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
`ifdef BD_TURNAROUND_EN
                        if (need_turn_s) begin
                            state_r <= ST_TURN;
                        end else begin
                            state_r <= ST_SETUP;
                        end
`else
                        state_r <= ST_SETUP;
`endif
                    end else begin
`ifdef BD_TURNAROUND_EN
                        // An idle gap means the next write is no longer back-to-back.
                        last_rd_r <= 1'b0;
`endif
                    end
                end
                ST_SETUP: begin
                    brd_n_r   <= ~rnw_r;
                    bwr_n_r   <= rnw_r;
                    stb_cnt_r <= strobe_len(dev_r, 4'(W_STB), 4'(S_STB)) - 4'd1;
                    state_r   <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (stb_cnt_r == 4'd0) begin
                        brd_n_r  <= 1'b1;
                        bwr_n_r  <= 1'b1;
                        r0_ack_r <= ~gnt1_r;
                        r1_ack_r <= gnt1_r;
                        if (rnw_r) begin
                            rdata_r <= bus.bd_in;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r  <= ST_HOLD;
                    end else begin
                        stb_cnt_r <= stb_cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    r0_ack_r     <= 1'b0;
                    r1_ack_r     <= 1'b0;
                    w5300_cs_n_r <= 1'b1;
                    sl811_cs_n_r <= 1'b1;
                    bd_oe_r      <= 1'b0;
`ifdef BD_TURNAROUND_EN
                    last_rd_r    <= rnw_r;
`endif
                    state_r      <= ST_IDLE;
                end
`ifdef BD_TURNAROUND_EN
                ST_TURN: begin
                    state_r <= ST_SETUP;
                end
`endif
                default: begin
                    state_r      <= ST_IDLE;
                    r0_ack_r     <= 1'b0;
                    r1_ack_r     <= 1'b0;
                    brd_n_r      <= 1'b1;
                    bwr_n_r      <= 1'b1;
                    w5300_cs_n_r <= 1'b1;
                    sl811_cs_n_r <= 1'b1;
                    bd_oe_r      <= 1'b0;
                end
            endcase

            // Selects, address and write data go valid on the SETUP cycle.
            if (enter_setup_s) begin
                w5300_cs_n_r <= (set_dev_s != DEV_W5300);
                sl811_cs_n_r <= (set_dev_s != DEV_SL811);
                w5300_addr_r <= set_addr_s;
                sl811_a0_r   <= set_addr_s[0];
                bd_oe_r      <= ~set_rnw_s;
                bd_out_r     <= set_wdata_s;
            end
        end
    end

    assign bus.r0_ack     = r0_ack_r;
    assign bus.r1_ack     = r1_ack_r;
    assign bus.rdata      = rdata_r;
    assign bus.bd_out     = bd_out_r;
    assign bus.bd_oe      = bd_oe_r;
    assign bus.brd_n      = brd_n_r;
    assign bus.bwr_n      = bwr_n_r;
    assign bus.w5300_cs_n = w5300_cs_n_r;
    assign bus.w5300_addr = w5300_addr_r;
    assign bus.sl811_cs_n = sl811_cs_n_r;
    assign bus.sl811_a0   = sl811_a0_r;
endmodule

// File: tb/tb_bd_bus_sched.sv
// tb_bd_bus_sched -- directed bench for bd_bus_sched (W_STB=3, S_STB=2,
// STARVE_MAX=4). Inputs change on the falling edge, outputs are sampled on
// the falling edge, so every sample sits half a clock from the active edge.
module tb_bd_bus_sched;
    import bd_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bd_bus_sched_if bus();

    bd_bus_sched #(.W_STB(3), .S_STB(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bd_bus_sched_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .w5300_cs_n (bus.w5300_cs_n),
        .sl811_cs_n (bus.sl811_cs_n),
        .brd_n      (bus.brd_n),
        .bwr_n      (bus.bwr_n),
        .r0_ack     (bus.r0_ack),
        .r1_ack     (bus.r1_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_txn, cycle 1 = SETUP.
    int         m_wcs, m_scs, m_rdl, m_wrl, m_oel, m_ack, m_oack;
    logic [7:0] m_rdata, m_bdout;
    logic [9:0] m_waddr;
    logic       m_a0;

    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at an IDLE falling edge and watch it to its ack.
    task automatic run_txn(input bit port, input bit rnw, input bit dev,
                           input logic [9:0] addr, input logic [7:0] wd,
                           input logic [7:0] bdin);
        logic own_ack, oth_ack;
        m_wcs = 0; m_scs = 0; m_rdl = 0; m_wrl = 0; m_oel = 0; m_ack = 0; m_oack = 0;
        m_rdata = 8'h00; m_bdout = 8'h00; m_waddr = 10'h000; m_a0 = 1'b0;
        bus.bd_in = bdin;
        if (port) begin
            bus.r1_rnw = rnw; bus.r1_dev = dev; bus.r1_addr = addr; bus.r1_wdata = wd;
            bus.r1_req = 1'b1;
        end else begin
            bus.r0_rnw = rnw; bus.r0_dev = dev; bus.r0_addr = addr; bus.r0_wdata = wd;
            bus.r0_req = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus.w5300_cs_n) begin m_wcs++; m_waddr = bus.w5300_addr; end
            if (!bus.sl811_cs_n) begin m_scs++; m_a0 = bus.sl811_a0; end
            if (!bus.brd_n) m_rdl++;
            if (!bus.bwr_n) begin m_wrl++; m_bdout = bus.bd_out; end
            if (bus.bd_oe) m_oel++;
            own_ack = port ? bus.r1_ack : bus.r0_ack;
            oth_ack = port ? bus.r0_ack : bus.r1_ack;
            if (oth_ack) m_oack++;
            if (own_ack) begin
                m_ack = i;
                m_rdata = bus.rdata;
                break;
            end
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
    endtask

    initial begin
        int got;
        int gap;
        int phase;
        bit found;
        int order [10];

        bus.r0_req = 1'b0; bus.r0_rnw = 1'b0; bus.r0_dev = 1'b0; bus.r0_addr = 10'h000; bus.r0_wdata = 8'h00;
        bus.r1_req = 1'b0; bus.r1_rnw = 1'b0; bus.r1_dev = 1'b0; bus.r1_addr = 10'h000; bus.r1_wdata = 8'h00;
        bus.bd_in = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check_vec("rst_brd_n", bus.brd_n, 1);
        check_vec("rst_bwr_n", bus.bwr_n, 1);
        check_vec("rst_w_cs_n", bus.w5300_cs_n, 1);
        check_vec("rst_s_cs_n", bus.sl811_cs_n, 1);
        check_vec("rst_bd_oe", bus.bd_oe, 0);
        check_vec("rst_acks", {bus.r0_ack, bus.r1_ack}, 0);
        check_vec("rst_rdata", bus.rdata, 0);
        check_vec("rst_bd_out", bus.bd_out, 0);
        check_vec("rst_addr", {bus.w5300_addr, bus.sl811_a0}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Port 0 write to W5300: 1 + 3 + 1 clocks.
        run_txn(1'b0, 1'b0, DEV_W5300, 10'h3A5, 8'h5C, 8'h00);
        check_vec("w_cs_cycles", m_wcs, 5);
        check_vec("w_wr_cycles", m_wrl, 3);
        check_vec("w_rd_cycles", m_rdl, 0);
        check_vec("w_oe_cycles", m_oel, 5);
        check_vec("w_ack_cycle", m_ack, 5);
        check_vec("w_bd_out", m_bdout, 8'h5C);
        check_vec("w_addr", m_waddr, 10'h3A5);
        check_vec("w_sl_cs", m_scs, 0);
        check_vec("w_other_ack", m_oack, 0);
        @(negedge clk);
        check_vec("w_idle_after", {bus.w5300_cs_n, bus.brd_n, bus.bwr_n, bus.bd_oe}, 4'b1110);

        // Port 1 read from SL811: 1 + 2 + 1 clocks.
        repeat (2) @(negedge clk);
        run_txn(1'b1, 1'b1, DEV_SL811, 10'h001, 8'h00, 8'hA7);
        check_vec("r_cs_cycles", m_scs, 4);
        check_vec("r_a0", m_a0, 1);
        check_vec("r_rd_cycles", m_rdl, 2);
        check_vec("r_wr_cycles", m_wrl, 0);
        check_vec("r_oe_cycles", m_oel, 0);
        check_vec("r_ack_cycle", m_ack, 4);
        check_vec("r_rdata", m_rdata, 8'hA7);
        check_vec("r_w_cs", m_wcs, 0);

        // Both ports held: starvation guard lets port 1 in every fifth grant.
        repeat (2) @(negedge clk);
        bus.r0_rnw = 1'b1; bus.r0_dev = DEV_W5300; bus.r0_addr = 10'h010;
        bus.r1_rnw = 1'b1; bus.r1_dev = DEV_SL811; bus.r1_addr = 10'h002;
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.r0_ack) begin order[got] = 0; got++; end
            else if (bus.r1_ack) begin order[got] = 1; got++; end
            if (got == 10) break;
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        check_vec("arb_grants", got, 10);
        for (int k = 0; k < 10; k++) begin
            if (k < got) check_vec($sformatf("arb_order_%0d", k), order[k], exp_order[k]);
        end

        // Reset during STROBE aborts the cycle, then a fresh cycle runs.
        repeat (2) @(negedge clk);
        bus.r0_rnw = 1'b0; bus.r0_dev = DEV_W5300; bus.r0_addr = 10'h155; bus.r0_wdata = 8'h33;
        bus.r0_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!bus.bwr_n) begin found = 1'b1; break; end
        end
        check_vec("abort_in_strobe", found, 1);
        rst_n = 1'b0;
        #1;
        check_vec("abort_idle_outs", {bus.bwr_n, bus.brd_n, bus.w5300_cs_n, bus.sl811_cs_n, bus.bd_oe}, 5'b11110);
        got = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) got++;
        end
        check_vec("abort_no_ack", got, 0);
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, DEV_W5300, 10'h155, 8'h33, 8'h00);
        check_vec("abort_fresh_ack", m_ack, 5);
        check_vec("abort_fresh_cs", m_wcs, 5);
        check_vec("abort_fresh_wr", m_wrl, 3);

        // Read then write back-to-back: the re-arbitration IDLE cycle is always
        // there; the turnaround build adds one more idle cycle.
        repeat (2) @(negedge clk);
        bus.bd_in = 8'h11;
        bus.r0_rnw = 1'b1; bus.r0_dev = DEV_W5300; bus.r0_addr = 10'h020; bus.r0_wdata = 8'h00;
        bus.r0_req = 1'b1;
        phase = 0; gap = 0; m_rdata = 8'h00; m_bdout = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phase == 0) begin
                if (bus.r0_ack) begin
                    m_rdata = bus.rdata;
                    bus.r0_rnw = 1'b0; bus.r0_wdata = 8'h99;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (bus.w5300_cs_n && bus.sl811_cs_n) gap++;
                else phase = 2;
            end else begin
                if (!bus.bwr_n) m_bdout = bus.bd_out;
                if (bus.r0_ack) begin phase = 3; break; end
            end
        end
        bus.r0_req = 1'b0;
        check_vec("turn_rd_data", m_rdata, 8'h11);
        check_vec("turn_wr_done", phase, 3);
`ifdef BD_TURNAROUND_EN
        check_vec("turn_gap", gap, 2);
`else
        check_vec("turn_gap", gap, 1);
`endif
        check_vec("turn_wr_data", m_bdout, 8'h99);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1);
    end
endmodule
